// File: rtl/surf_cmd_decoder.sv
// rtl/surf_cmd_decoder.sv - SURF spliced-command decoder: PPS, runcmd, trigger and firmware-byte streams
// Define SURF_CMD_DECODER_STATS_EN to build the protocol-error and overflow counters.
module surf_cmd_decoder #(
  parameter int TRIG_FIFO_DEPTH = 4,
  parameter int FW_FIFO_DEPTH   = 16
) (
  input  logic        sysclk_i,
  input  logic        rst_n_i,
  input  logic        command_locked_i,
  input  logic [31:0] command_i,
  input  logic        command_valid_i,
  output logic        pps_o,
  output logic [1:0]  runcmd_tdata,
  output logic        runcmd_tvalid,
  input  logic        runcmd_tready,
  output logic [14:0] trig_tdata,
  output logic        trig_tvalid,
  input  logic        trig_tready,
  output logic [7:0]  fw_tdata,
  output logic        fw_tlast,
  output logic        fw_tvalid,
  input  logic        fw_tready,
  output logic [15:0] proto_err_count_o,
  output logic [15:0] overflow_count_o,
  input  logic        count_clear_i
);
  localparam int TAW = $clog2(TRIG_FIFO_DEPTH);
  localparam int FAW = $clog2(FW_FIFO_DEPTH);
  localparam logic [TAW:0] TRIG_FULL = (TAW+1)'(TRIG_FIFO_DEPTH);
  localparam logic [FAW:0] FW_FULL   = (FAW+1)'(FW_FIFO_DEPTH);

  typedef enum logic {FW_IDLE, FW_FRAME} fw_state_t;

  logic        acc_q, lock_q, flush;
  logic [31:0] word_q;
  fw_state_t   fw_state, fw_next;
  logic        fw_push, fw_last, fw_err;
  logic        rc_load, rc_ovf, word_perr;
  logic        trig_push_q, fw_push_q, perr_q, rc_ovf_q;
  logic [14:0] trig_data_q;
  logic [8:0]  fw_data_q;

  // Falling edge of lock flushes everything downstream of the input register.
  assign flush = lock_q & ~command_locked_i;

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= 1'b0;
      lock_q <= 1'b0;
      word_q <= '0;
    end else begin
      acc_q  <= command_valid_i & command_locked_i;
      lock_q <= command_locked_i;
      if (command_valid_i && command_locked_i) word_q <= command_i;
    end
  end

  always_comb begin
    fw_next = fw_state;
    fw_push = 1'b0;
    fw_last = 1'b0;
    fw_err  = 1'b0;
    if (acc_q && word_q[12]) begin
      case (word_q[11:10])
        2'b01: begin
          fw_push = 1'b1;
          fw_err  = (fw_state == FW_FRAME);
          fw_next = FW_FRAME;
        end
        2'b11: begin
          fw_push = 1'b1;
          fw_last = 1'b1;
          fw_err  = (fw_state == FW_FRAME);
          fw_next = FW_IDLE;
        end
        2'b00: begin
          fw_push = (fw_state == FW_FRAME);
          fw_err  = (fw_state == FW_IDLE);
        end
        default: begin
          fw_push = (fw_state == FW_FRAME);
          fw_last = 1'b1;
          fw_err  = (fw_state == FW_IDLE);
          fw_next = FW_IDLE;
        end
      endcase
    end
    if (flush) fw_next = FW_IDLE;
  end

  assign rc_load   = acc_q & (word_q[30:29] != 2'b00);
  assign rc_ovf    = rc_load & runcmd_tvalid & ~runcmd_tready;
  assign word_perr = fw_err | (acc_q & (word_q[9:8] != 2'b00));

  // Error flags ride along with the FIFO pushes so one word bumps each counter at most once.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fw_state      <= FW_IDLE;
      pps_o         <= 1'b0;
      perr_q        <= 1'b0;
      rc_ovf_q      <= 1'b0;
      trig_push_q   <= 1'b0;
      fw_push_q     <= 1'b0;
      trig_data_q   <= '0;
      fw_data_q     <= '0;
      runcmd_tvalid <= 1'b0;
      runcmd_tdata  <= '0;
    end else begin
      fw_state    <= fw_next;
      pps_o       <= acc_q & word_q[31];
      perr_q      <= word_perr;
      rc_ovf_q    <= rc_ovf;
      trig_push_q <= acc_q & word_q[28] & ~flush;
      fw_push_q   <= fw_push & ~flush;
      trig_data_q <= word_q[27:13];
      fw_data_q   <= {fw_last, word_q[7:0]};
      if (flush) begin
        runcmd_tvalid <= 1'b0;
      end else if (rc_load) begin
        runcmd_tvalid <= 1'b1;
        runcmd_tdata  <= word_q[30:29];
      end else if (runcmd_tready) begin
        runcmd_tvalid <= 1'b0;
      end
    end
  end

  logic [14:0]    trig_mem [TRIG_FIFO_DEPTH];
  logic [TAW-1:0] trig_wr, trig_rd;
  logic [TAW:0]   trig_cnt;
  logic           trig_pop, trig_wr_en, trig_ovf;

  assign trig_tvalid = (trig_cnt != '0);
  assign trig_tdata  = trig_tvalid ? trig_mem[trig_rd] : '0;
  assign trig_pop    = trig_tvalid & trig_tready;
  assign trig_wr_en  = trig_push_q & ((trig_cnt != TRIG_FULL) | trig_pop);
  assign trig_ovf    = trig_push_q & ~trig_wr_en;

  always_ff @(posedge sysclk_i) begin
    if (trig_wr_en) trig_mem[trig_wr] <= trig_data_q;
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i || flush) begin
      trig_wr  <= '0;
      trig_rd  <= '0;
      trig_cnt <= '0;
    end else begin
      if (trig_wr_en) trig_wr <= trig_wr + 1'b1;
      if (trig_pop)   trig_rd <= trig_rd + 1'b1;
      trig_cnt <= trig_cnt + (TAW+1)'(trig_wr_en) - (TAW+1)'(trig_pop);
    end
  end

  logic [8:0]     fw_mem [FW_FIFO_DEPTH];
  logic [FAW-1:0] fw_wr, fw_rd;
  logic [FAW:0]   fw_cnt;
  logic [8:0]     fw_head;
  logic           fw_pop, fw_wr_en, fw_ovf;

  assign fw_tvalid = (fw_cnt != '0);
  assign fw_head   = fw_tvalid ? fw_mem[fw_rd] : '0;
  assign fw_tdata  = fw_head[7:0];
  assign fw_tlast  = fw_head[8];
  assign fw_pop    = fw_tvalid & fw_tready;
  assign fw_wr_en  = fw_push_q & ((fw_cnt != FW_FULL) | fw_pop);
  assign fw_ovf    = fw_push_q & ~fw_wr_en;

  always_ff @(posedge sysclk_i) begin
    if (fw_wr_en) fw_mem[fw_wr] <= fw_data_q;
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i || flush) begin
      fw_wr  <= '0;
      fw_rd  <= '0;
      fw_cnt <= '0;
    end else begin
      if (fw_wr_en) fw_wr <= fw_wr + 1'b1;
      if (fw_pop)   fw_rd <= fw_rd + 1'b1;
      fw_cnt <= fw_cnt + (FAW+1)'(fw_wr_en) - (FAW+1)'(fw_pop);
    end
  end

  logic any_ovf;
  assign any_ovf = rc_ovf_q | trig_ovf | fw_ovf;

`ifdef SURF_CMD_DECODER_STATS_EN
  logic [15:0] perr_cnt, ovf_cnt;

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perr_cnt <= '0;
      ovf_cnt  <= '0;
    end else if (count_clear_i) begin
      perr_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (perr_q && perr_cnt != 16'hFFFF) perr_cnt <= perr_cnt + 16'd1;
      if (any_ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign proto_err_count_o = perr_cnt;
  assign overflow_count_o  = ovf_cnt;
`else
  logic unused_stats;
  assign unused_stats      = ^{count_clear_i, perr_q, any_ovf};
  assign proto_err_count_o = '0;
  assign overflow_count_o  = '0;
`endif

endmodule

// File: tb/tb_surf_cmd_decoder.sv
// tb/tb_surf_cmd_decoder.sv - scoreboard bench for surf_cmd_decoder with a spec-level reference model
module tb_surf_cmd_decoder;
  localparam int TRIG_DEPTH = 4;
`ifdef SURF_CMD_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        sysclk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        command_locked_i = 1'b1;
  logic [31:0] command_i = '0;
  logic        command_valid_i = 1'b0;
  logic        pps_o;
  logic [1:0]  runcmd_tdata;
  logic        runcmd_tvalid;
  logic        runcmd_tready = 1'b1;
  logic [14:0] trig_tdata;
  logic        trig_tvalid;
  logic        trig_tready = 1'b1;
  logic [7:0]  fw_tdata;
  logic        fw_tlast;
  logic        fw_tvalid;
  logic        fw_tready = 1'b1;
  logic [15:0] proto_err_count_o;
  logic [15:0] overflow_count_o;
  logic        count_clear_i = 1'b0;

  surf_cmd_decoder #(.TRIG_FIFO_DEPTH(TRIG_DEPTH), .FW_FIFO_DEPTH(16)) dut (
    .sysclk_i(sysclk_i), .rst_n_i(rst_n_i), .command_locked_i(command_locked_i),
    .command_i(command_i), .command_valid_i(command_valid_i), .pps_o(pps_o),
    .runcmd_tdata(runcmd_tdata), .runcmd_tvalid(runcmd_tvalid), .runcmd_tready(runcmd_tready),
    .trig_tdata(trig_tdata), .trig_tvalid(trig_tvalid), .trig_tready(trig_tready),
    .fw_tdata(fw_tdata), .fw_tlast(fw_tlast), .fw_tvalid(fw_tvalid), .fw_tready(fw_tready),
    .proto_err_count_o(proto_err_count_o), .overflow_count_o(overflow_count_o),
    .count_clear_i(count_clear_i)
  );

  always #5 sysclk_i = ~sysclk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge sysclk_i) cyc <= cyc + 1;

  logic [14:0] trig_q[$];
  logic [8:0]  fw_q[$];
  logic [1:0]  rc_q[$];
  int          pps_q[$];
  int          exp_perr = 0;
  int          exp_ovf = 0;
  bit          model_frame = 1'b0;
  bit          trig_stalled = 1'b0;
  bit          rc_stalled = 1'b0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: applies the decode rules to one accepted word.
  task automatic model_word(input logic [31:0] w);
    bit err, ovf;
    err = (w[9:8] != 2'b00);
    ovf = 1'b0;
    if (w[31]) pps_q.push_back(cyc + 2);
    if (w[30:29] != 2'b00) begin
      if (rc_stalled && rc_q.size() > 0) begin
        rc_q[0] = w[30:29];
        ovf = 1'b1;
      end else rc_q.push_back(w[30:29]);
    end
    if (w[28]) begin
      if (trig_stalled && trig_q.size() >= TRIG_DEPTH) ovf = 1'b1;
      else trig_q.push_back(w[27:13]);
    end
    if (w[12]) begin
      case (w[11:10])
        2'b01: begin if (model_frame) err = 1'b1; fw_q.push_back({1'b0, w[7:0]}); model_frame = 1'b1; end
        2'b11: begin if (model_frame) err = 1'b1; fw_q.push_back({1'b1, w[7:0]}); model_frame = 1'b0; end
        2'b00: begin if (model_frame) fw_q.push_back({1'b0, w[7:0]}); else err = 1'b1; end
        default: begin
          if (model_frame) begin fw_q.push_back({1'b1, w[7:0]}); model_frame = 1'b0; end
          else err = 1'b1;
        end
      endcase
    end
    if (err) exp_perr++;
    if (ovf) exp_ovf++;
  endtask

  task automatic send_word(input logic [31:0] w, input bit v);
    command_i = w;
    command_valid_i = v;
    if (v && command_locked_i) model_word(w);
    @(posedge sysclk_i); #1;
    command_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] trig_word(input logic [14:0] t);
    return {3'b000, 1'b1, t, 13'b0};
  endfunction

  function automatic logic [31:0] fw_word(input logic [1:0] mark, input logic [1:0] res, input logic [7:0] b);
    return {19'b0, 1'b1, mark, res, b};
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_proto_err_count"}, 32'(proto_err_count_o), STATS ? 32'(exp_perr) : 32'd0);
    check({tag, "_overflow_count"}, 32'(overflow_count_o), STATS ? 32'(exp_ovf) : 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((trig_q.size() + fw_q.size() + rc_q.size() + pps_q.size()) != 0 && n < 400) begin
      @(posedge sysclk_i);
      n++;
    end
    #1;
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: got %0d items still pending expected 0", tag,
               trig_q.size() + fw_q.size() + rc_q.size() + pps_q.size());
    end
    repeat (3) @(posedge sysclk_i);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a stream transfers.
  always @(negedge sysclk_i) begin
    if (rst_n_i) begin
      if (trig_tvalid && trig_tready) begin
        if (trig_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL trig_extra: got %0h expected nothing", trig_tdata);
        end else check("trig_data", 32'(trig_tdata), 32'(trig_q.pop_front()));
      end
      if (fw_tvalid && fw_tready) begin
        if (fw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fw_extra: got %0h expected nothing", {fw_tlast, fw_tdata});
        end else check("fw_last_data", 32'({fw_tlast, fw_tdata}), 32'(fw_q.pop_front()));
      end
      if (runcmd_tvalid && runcmd_tready) begin
        if (rc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL runcmd_extra: got %0h expected nothing", runcmd_tdata);
        end else check("runcmd_data", 32'(runcmd_tdata), 32'(rc_q.pop_front()));
      end
      if (pps_q.size() > 0 && pps_q[0] == cyc) begin
        check("pps_pulse", 32'(pps_o), 32'd1);
        void'(pps_q.pop_front());
      end else if (pps_o) check("pps_spurious", 32'(pps_o), 32'd0);
    end
  end

  always @(posedge sysclk_i) begin
    if (rand_rdy) begin
      #1;
      trig_tready = 1'($urandom_range(1));
      fw_tready   = 1'($urandom_range(1));
    end
  end

  task automatic run_random();
    int nt, gap;
    logic [31:0] w;
    bit v;
    for (int b = 0; b < 25; b++) begin
      nt = 0;
      for (int i = 0; i < 6; i++) begin
        w = $urandom;
        if (w[28]) begin
          if (nt >= TRIG_DEPTH) w[28] = 1'b0;
          else nt++;
        end
        if ($urandom_range(3) != 0) w[9:8] = 2'b00;
        v = ($urandom_range(4) != 0);
        send_word(w, v);
        gap = $urandom_range(2);
        for (int g = 0; g < gap; g++) begin @(posedge sysclk_i); #1; end
      end
      wait_drain("random");
      check_counts("random");
    end
  endtask

  initial begin
    repeat (3) @(posedge sysclk_i);
    #1 rst_n_i = 1'b1;
    @(negedge sysclk_i);
    check("reset_pps", 32'(pps_o), 32'd0);
    check("reset_tvalids", 32'({runcmd_tvalid, trig_tvalid, fw_tvalid}), 32'd0);
    check("reset_tdata", 32'({runcmd_tdata, trig_tdata, fw_tdata, fw_tlast}), 32'd0);
    check_counts("reset");
    @(posedge sysclk_i); #1;

    send_word(32'h8000_0000, 1'b1);
    repeat (3) @(negedge sysclk_i);
    check("pps_only_tvalids", 32'({runcmd_tvalid, trig_tvalid, fw_tvalid}), 32'd0);
    @(posedge sysclk_i); #1;

    runcmd_tready = 1'b0;
    rc_stalled = 1'b1;
    send_word(32'h4000_0000, 1'b1);
    send_word(32'h6000_0000, 1'b1);
    repeat (4) @(negedge sysclk_i);
    check("runcmd_overwrite", 32'({runcmd_tvalid, runcmd_tdata}), 32'h7);
    check_counts("runcmd_ovf");
    @(posedge sysclk_i); #1;
    runcmd_tready = 1'b1;
    rc_stalled = 1'b0;
    wait_drain("runcmd");

    trig_tready = 1'b0;
    trig_stalled = 1'b1;
    for (int i = 1; i <= 5; i++) send_word(trig_word(15'(i)), 1'b1);
    repeat (4) @(negedge sysclk_i);
    check("trig_stall_head", 32'({trig_tvalid, trig_tdata}), 32'h8001);
    check_counts("trig_ovf");
    @(posedge sysclk_i); #1;
    trig_tready = 1'b1;
    trig_stalled = 1'b0;
    wait_drain("trig");

    send_word(fw_word(2'b01, 2'b00, 8'hAA), 1'b1);
    @(negedge sysclk_i);
    @(negedge sysclk_i);
    check("fw_latency_early", 32'(fw_tvalid), 32'd0);
    @(negedge sysclk_i);
    check("fw_latency_n2", 32'(fw_tvalid), 32'd1);
    @(posedge sysclk_i); #1;
    send_word(fw_word(2'b00, 2'b00, 8'hBB), 1'b1);
    send_word(fw_word(2'b10, 2'b00, 8'hCC), 1'b1);
    wait_drain("fw_frame");
    check_counts("fw_frame");

    send_word(fw_word(2'b00, 2'b00, 8'hDD), 1'b1);
    send_word(fw_word(2'b01, 2'b11, 8'hEE), 1'b1);
    wait_drain("fw_proto");
    check_counts("fw_proto");

    trig_tready = 1'b0;
    fw_tready = 1'b0;
    trig_stalled = 1'b1;
    send_word(trig_word(15'h0011), 1'b1);
    send_word(trig_word(15'h0022), 1'b1);
    send_word(fw_word(2'b00, 2'b00, 8'h33), 1'b1);
    repeat (4) @(negedge sysclk_i);
    check("prelock_tvalids", 32'({trig_tvalid, fw_tvalid}), 32'h3);
    @(posedge sysclk_i); #1;
    command_locked_i = 1'b0;
    trig_q.delete();
    fw_q.delete();
    rc_q.delete();
    model_frame = 1'b0;
    repeat (2) @(negedge sysclk_i);
    check("flush_tvalids", 32'({runcmd_tvalid, trig_tvalid, fw_tvalid}), 32'd0);
    @(posedge sysclk_i); #1;
    command_locked_i = 1'b1;
    trig_stalled = 1'b0;
    @(posedge sysclk_i); #1;
    send_word(fw_word(2'b00, 2'b00, 8'h11), 1'b1);
    repeat (4) @(negedge sysclk_i);
    check("postlock_fw_drop", 32'(fw_tvalid), 32'd0);
    check_counts("lock_loss");
    @(posedge sysclk_i); #1;
    trig_tready = 1'b1;
    fw_tready = 1'b1;

    rand_rdy = 1'b1;
    run_random();
    rand_rdy = 1'b0;
    @(posedge sysclk_i); #1;

    count_clear_i = 1'b1;
    @(posedge sysclk_i); #1;
    count_clear_i = 1'b0;
    exp_perr = 0;
    exp_ovf = 0;
    check_counts("clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
